// File: rtl/des_pkg.sv
// Shared DES types, the E/P/S-box tables and the round function f(R, K).
// Table entries use the DES convention: bit 1 is the MSB of the word.
package des_pkg;

    typedef logic [31:0] des_half_t;
    typedef logic [63:0] des_block_t;
    typedef logic [47:0] des_rkey_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} des_eng_state_t;

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is flattened row-major: index = row*16 + col.
    localparam int S_TAB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic des_half_t des_f(input des_half_t r, input des_rkey_t k);
        des_rkey_t  x;
        des_half_t  s;
        des_half_t  p;
        logic [5:0] b;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_TAB[6'(i)])];
        x = x ^ k;
        // Outer bits of each 6-bit group pick the row, inner four the column.
        for (int j = 0; j < 8; j++) begin
            b = x[6'(47 - 6*j) -: 6];
            s[5'(31 - 4*j) -: 4] = 4'(S_TAB[3'(j)][{b[5], b[0], b[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_TAB[5'(i)])];
        return p;
    endfunction

endpackage

// File: rtl/DES_round_wrapper.sv
// One combinational Feistel round: L' = R, R' = L ^ f(R, K).
module DES_round_wrapper
    import des_pkg::*;
(
    input  des_half_t in_left,
    input  des_half_t in_right,
    input  des_rkey_t round_key,
    output des_half_t out_left,
    output des_half_t out_right
);

    assign out_left  = in_right;
    assign out_right = in_left ^ des_f(in_right, round_key);

endmodule

// File: rtl/des_feistel_engine.sv
// Iterative DES Feistel core: NUM_ROUNDS rounds, UNROLL chained rounds per clock,
// round keys read combinationally from an external key store via key_idx.
module des_feistel_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int UNROLL     = 1,
    parameter bit FINAL_SWAP = 1'b1,
    localparam int IDXW      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
)(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [63:0]            in_block,
    output logic [UNROLL*IDXW-1:0] key_idx,
    input  logic [UNROLL*48-1:0]   key_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_block
);

    localparam int P    = NUM_ROUNDS / UNROLL;
    localparam int CNTW = (P > 1) ? $clog2(P) : 1;

    des_eng_state_t       state;
    des_half_t            l_q, r_q;
    logic [CNTW-1:0]      cnt;
    logic                 mode_q;
    des_half_t [UNROLL:0] l_chain, r_chain;
    des_block_t           res;
    logic                 accept;

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign l_chain[0] = l_q;
    assign r_chain[0] = r_q;

    // Indices depend only on registered cnt/mode so the key store sees a stable address.
    for (genvar j = 0; j < UNROLL; j++) begin : g_lane
        logic [IDXW-1:0] k;
        assign k = (state == RUN) ? IDXW'(int'(cnt) * UNROLL + j) : '0;
        assign key_idx[j*IDXW +: IDXW] = mode_q ? IDXW'(NUM_ROUNDS - 1) - k : k;

        DES_round_wrapper u_round (
            .in_left   (l_chain[j]),
            .in_right  (r_chain[j]),
            .round_key (key_in[j*48 +: 48]),
            .out_left  (l_chain[j+1]),
            .out_right (r_chain[j+1])
        );
    end

    assign res = FINAL_SWAP ? {r_chain[UNROLL], l_chain[UNROLL]}
                            : {l_chain[UNROLL], r_chain[UNROLL]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            l_q       <= '0;
            r_q       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the back-to-back hand-off out of DONE.
            state     <= RUN;
            l_q       <= in_block[63:32];
            r_q       <= in_block[31:0];
            mode_q    <= in_mode;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    l_q <= l_chain[UNROLL];
                    r_q <= r_chain[UNROLL];
                    if (cnt == CNTW'(P - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_block <= res;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
